// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: NCH prescaler channels, each emitting
// a one-cycle tick every div cycles, periodic or one-shot, with runtime divisor writes.
module tick_gen_multi #(
  parameter int NCH     = 4,
  parameter int W       = 31,
  parameter int DEF_DIV = 50000000,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clki,
  input  logic           reset_n,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_ch,
  input  logic [W-1:0]   wr_div,
  input  logic [NCH-1:0] ch_en,
  input  logic [NCH-1:0] ch_oneshot,
  input  logic [NCH-1:0] start,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] busy,
  output logic           err
);

  localparam logic [CW:0] NCH_L = (CW+1)'(NCH);

  logic [W-1:0]   cnt [NCH];
  logic [W-1:0]   div [NCH];
  logic [NCH-1:0] mode_q;
  logic           wr_bad;
  logic           wr_ok;

  // A write is rejected for a zero divisor or a channel index past the last channel.
  assign wr_bad = wr_en && ((wr_div == '0) || ({1'b0, wr_ch} >= NCH_L));
  assign wr_ok  = wr_en && !wr_bad;

  // Per-channel priority: write, then mode change / disable, then start, then counting.
  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        div[i] <= W'(DEF_DIV);
      end
      mode_q <= '0;
      busy   <= '0;
      tick   <= '0;
      err    <= 1'b0;
    end else begin
      err <= wr_bad;
      for (int i = 0; i < NCH; i++) begin
        mode_q[i] <= ch_oneshot[i];
        if (wr_ok && (wr_ch == CW'(i))) begin
          div[i]  <= wr_div;
          cnt[i]  <= '0;
          busy[i] <= 1'b0;
          tick[i] <= 1'b0;
        end else if ((ch_oneshot[i] != mode_q[i]) || !ch_en[i]) begin
          cnt[i]  <= '0;
          busy[i] <= 1'b0;
          tick[i] <= 1'b0;
        end else if (mode_q[i] && start[i]) begin
          cnt[i]  <= '0;
          busy[i] <= 1'b1;
          tick[i] <= 1'b0;
        end else if (!mode_q[i] || busy[i]) begin
          if (cnt[i] == (div[i] - W'(1))) begin
            cnt[i]  <= '0;
            tick[i] <= 1'b1;
            if (mode_q[i]) begin
              busy[i] <= 1'b0;
            end
          end else begin
            cnt[i]  <= cnt[i] + W'(1);
            tick[i] <= 1'b0;
          end
        end else begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: directed scenarios with hand-derived
// expectations plus randomized traffic checked against an elapsed-cycle model.
module tb_tick_gen_multi;

  localparam int NCH     = 3;
  localparam int W       = 16;
  localparam int DEF_DIV = 5;
  localparam int CW      = 2;

  logic           clki = 1'b0;
  logic           reset_n;
  logic           wr_en;
  logic [CW-1:0]  wr_ch;
  logic [W-1:0]   wr_div;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] ch_oneshot;
  logic [NCH-1:0] start;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] busy;
  logic           err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: each channel tracks cycles elapsed since its run began.
  int             m_age  [NCH];
  logic [W-1:0]   m_div  [NCH];
  bit             m_mode [NCH];
  bit             m_arm  [NCH];
  logic [NCH-1:0] exp_tick;
  logic [NCH-1:0] exp_busy;
  logic           exp_err;

  always #5 clki = ~clki;

  tick_gen_multi #(.NCH(NCH), .W(W), .DEF_DIV(DEF_DIV)) dut (
    .clki(clki), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .ch_en(ch_en), .ch_oneshot(ch_oneshot), .start(start),
    .tick(tick), .busy(busy), .err(err)
  );

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_age[c]  = 0;
      m_div[c]  = W'(DEF_DIV);
      m_mode[c] = 1'b0;
      m_arm[c]  = 1'b0;
    end
    exp_tick = '0;
    exp_busy = '0;
    exp_err  = 1'b0;
  endtask

  task automatic model_update();
    exp_err = wr_en && ((wr_div == '0) || (int'(wr_ch) >= NCH));
    for (int c = 0; c < NCH; c++) begin
      bit hit;
      hit = wr_en && (wr_div != '0) && (int'(wr_ch) == c);
      if (hit) begin
        m_div[c] = wr_div; m_age[c] = 0; m_arm[c] = 0; exp_tick[c] = 0;
        m_mode[c] = ch_oneshot[c];
      end else if (ch_oneshot[c] != m_mode[c]) begin
        m_mode[c] = ch_oneshot[c]; m_age[c] = 0; m_arm[c] = 0; exp_tick[c] = 0;
      end else if (!ch_en[c]) begin
        m_age[c] = 0; m_arm[c] = 0; exp_tick[c] = 0;
      end else if (m_mode[c] && start[c]) begin
        m_arm[c] = 1; m_age[c] = 0; exp_tick[c] = 0;
      end else if (!m_mode[c]) begin
        m_age[c]++;
        exp_tick[c] = (m_age[c] % int'(m_div[c])) == 0;
      end else if (m_arm[c]) begin
        m_age[c]++;
        if (m_age[c] == int'(m_div[c])) begin
          exp_tick[c] = 1; m_arm[c] = 0; m_age[c] = 0;
        end else begin
          exp_tick[c] = 0;
        end
      end else begin
        exp_tick[c] = 0;
      end
      exp_busy[c] = m_arm[c];
    end
  endtask

  // One clock edge; write and start strobes are single-cycle and drop after the edge.
  task automatic step();
    @(posedge clki);
    model_update();
    #1;
    wr_en = 1'b0;
    start = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    ch_en = '0; ch_oneshot = '0; start = '0;
    repeat (2) @(posedge clki);
    #2 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    ch_en = '1; ch_oneshot = '0; start = '0;
    repeat (2) @(posedge clki);
    #1;
    n_checks++;
    if ({tick, busy, err} !== '0) $display("FAIL reset outputs: got %b expected 0", {tick, busy, err});
    else n_pass++;
    #1 reset_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (tick !== ((k == 5) ? 3'b111 : 3'b000))
        $display("FAIL reset first period k=%0d: got %b expected %b", k, tick, (k == 5) ? 3'b111 : 3'b000);
      else n_pass++;
    end
  endtask

  task automatic test_periodic();
    logic [NCH-1:0] e;
    do_reset();
    ch_en = 3'b001;
    for (int k = 1; k <= 20; k++) begin
      step();
      e = (k % 5 == 0) ? 3'b001 : 3'b000;
      n_checks++;
      if (tick !== e) $display("FAIL periodic tick k=%0d: got %b expected %b", k, tick, e);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 3'b000) $display("FAIL periodic busy: got %b expected 000", busy);
    else n_pass++;
  endtask

  task automatic test_div_write();
    logic [NCH-1:0] e;
    do_reset();
    ch_en = 3'b010;
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd1;
    step();
    n_checks++;
    if (tick !== 3'b000) $display("FAIL div1 write edge: got %b expected 000", tick);
    else n_pass++;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++;
      if (tick !== 3'b010) $display("FAIL div1 constant k=%0d: got %b expected 010", k, tick);
      else n_pass++;
    end
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd7;
    for (int k = 0; k <= 3; k++) begin
      step();
      n_checks++;
      if (tick !== 3'b000) $display("FAIL div7 midcount k=%0d: got %b expected 000", k, tick);
      else n_pass++;
    end
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd3;
    for (int k = 0; k <= 9; k++) begin
      step();
      e = (k != 0 && k % 3 == 0) ? 3'b010 : 3'b000;
      n_checks++;
      if (tick !== e) $display("FAIL div3 after write k=%0d: got %b expected %b", k, tick, e);
      else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    ch_oneshot = 3'b100; ch_en = 3'b100;
    step();
    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd4;
    step();
    for (int pass = 0; pass < 2; pass++) begin
      start = 3'b100;
      step();
      if (pass == 1) begin
        step(); step();
        start = 3'b100;
        step();
      end
      n_checks++;
      if ({tick, busy} !== 6'b000_100) $display("FAIL oneshot start pass=%0d: got %b expected 000100", pass, {tick, busy});
      else n_pass++;
      for (int k = 1; k <= 7; k++) begin
        step();
        n_checks++;
        if (tick !== ((k == 4) ? 3'b100 : 3'b000) || busy !== ((k < 4) ? 3'b100 : 3'b000))
          $display("FAIL oneshot pass=%0d k=%0d: got tick=%b busy=%b expected tick=%b busy=%b", pass, k,
                   tick, busy, (k == 4) ? 3'b100 : 3'b000, (k < 4) ? 3'b100 : 3'b000);
        else n_pass++;
      end
    end
  endtask

  task automatic test_rejected();
    logic [NCH-1:0] e;
    do_reset();
    ch_en = 3'b001;
    for (int k = 1; k <= 15; k++) begin
      if (k == 3) begin wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd0; end
      if (k == 6) begin wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd2; end
      step();
      e = (k % 5 == 0) ? 3'b001 : 3'b000;
      n_checks++;
      if (err !== (k == 3 || k == 6) || tick !== e)
        $display("FAIL rejected write k=%0d: got err=%b tick=%b expected err=%b tick=%b", k, err, tick,
                 (k == 3 || k == 6), e);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    do_reset();
    ch_oneshot = 3'b100; ch_en = 3'b100;
    step();
    start = 3'b100;
    step(); step(); step();
    ch_en = 3'b000;
    step();
    ch_en = 3'b100;
    for (int k = 0; k <= 7; k++) begin
      n_checks++;
      if ({tick, busy} !== 6'b0) $display("FAIL abort en-drop k=%0d: got %b expected 000000", k, {tick, busy});
      else n_pass++;
      step();
    end

    do_reset();
    ch_en = 3'b001;
    step(); step(); step();
    ch_oneshot = 3'b001;
    step();
    ch_oneshot = 3'b000;
    step();
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) step();
      n_checks++;
      if (tick !== ((j > 0 && j % 5 == 0) ? 3'b001 : 3'b000) || busy !== 3'b000)
        $display("FAIL abort mode toggle j=%0d: got tick=%b busy=%b", j, tick, busy);
      else n_pass++;
    end

    do_reset();
    ch_oneshot = 3'b100; ch_en = 3'b100;
    step();
    start = 3'b100;
    step(); step();
    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd3; start = 3'b100;
    step();
    for (int k = 0; k <= 6; k++) begin
      n_checks++;
      if ({tick, busy} !== 6'b0) $display("FAIL abort write-vs-start k=%0d: got %b expected 000000", k, {tick, busy});
      else n_pass++;
      step();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ch_en = 3'b111; ch_oneshot = 3'b100;
    step();
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd1;
    step();
    start = 3'b100;
    step();
    n_checks++;
    if ({tick[1], busy[2]} !== 2'b11) $display("FAIL pre-reset activity: got %b expected 11", {tick[1], busy[2]});
    else n_pass++;
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({tick, busy, err} !== '0) $display("FAIL async reset immediate: got %b expected 0", {tick, busy, err});
    else n_pass++;
    @(posedge clki);
    #1;
    n_checks++;
    if ({tick, busy, err} !== '0) $display("FAIL async reset held: got %b expected 0", {tick, busy, err});
    else n_pass++;
    ch_oneshot = 3'b000;
    #2 reset_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (tick !== ((k % 5 == 0) ? 3'b111 : 3'b000))
        $display("FAIL after reset div k=%0d: got %b expected %b", k, tick, (k % 5 == 0) ? 3'b111 : 3'b000);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    ch_en = '1;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(15) == 0) ch_en[i] = ~ch_en[i];
        if ($urandom_range(31) == 0) ch_oneshot[i] = ~ch_oneshot[i];
        start[i] = ($urandom_range(5) == 0);
      end
      wr_en  = ($urandom_range(11) == 0);
      wr_ch  = CW'($urandom_range(3));
      wr_div = W'($urandom_range(6));
      step();
      n_checks++;
      if ({tick, busy, err} !== {exp_tick, exp_busy, exp_err})
        $display("FAIL random n=%0d: got tick=%b busy=%b err=%b expected tick=%b busy=%b err=%b",
                 n, tick, busy, err, exp_tick, exp_busy, exp_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_div_write();
    test_oneshot();
    test_rejected();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tick_gen_multi.md
# tick_gen_multi

Multi-channel programmable tick generator: NCH independent prescaler channels, each producing a one-cycle tick every DIV clock cycles. Each channel runs periodic or one-shot and has a divisor that is writable at runtime. It replaces fixed-divisor tick generation in the display and timing paths, such as LCD refresh, cursor blink and debounce, where several rates are needed from one 50 MHz clock.

## Interface
- NCH, 4: number of channels (1..16).
- W, 31: divisor/counter width.
- DEF_DIV, 50000000: divisor loaded into every channel at reset. Must be in 1..2^W-1.
- CW, max(1, clog2(NCH)): channel-select width. Derived, not overridable.

- clki  in  1: clock, 50 MHz, rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- wr_en  in  1: divisor write strobe.
- wr_ch  in  CW: target channel of the write.
- wr_div  in  W: new divisor, in cycles per tick.
- ch_en  in  NCH: per-channel run enable, level.
- ch_oneshot  in  NCH: per-channel mode, level. 1 = one-shot, 0 = periodic.
- start  in  NCH: per-channel one-shot trigger, sampled at each edge.
- tick  out  NCH: registered one-cycle tick pulse per channel.
- busy  out  NCH: one-shot armed and counting.
- err  out  1: one-cycle pulse for a rejected write.

## Operation
- Per-channel state:
  - cnt[W], div[W], busy, tick.
  - mode_q, a registered copy of ch_oneshot[i].
- A channel is active when ch_en[i]=1 and either mode_q=0 (periodic) or busy=1 (one-shot).
- Active channel, at each edge:
  - If cnt==div-1: cnt<=0 and tick<=1. In one-shot mode, also busy<=0.
  - Otherwise: cnt<=cnt+1 and tick<=0.
- Inactive channel: cnt<=0, tick<=0. Clearing ch_en also clears busy.
- one-shot start (mode_q=1, ch_en=1, start[i]=1): busy<=1, cnt<=0, tick<=0.
  - Retrigger while busy restarts the count.
  - A start in the same cycle as the terminal count wins; that tick is suppressed.
- start is ignored in periodic mode and when ch_en=0.
- Mode change: whenever ch_oneshot[i] differs from mode_q, at that edge mode_q updates, and cnt<=0, busy<=0, tick<=0.
- Divisor write (wr_en=1, wr_ch<NCH, wr_div!=0):
  - div[wr_ch]<=wr_div, cnt<=0, busy<=0, tick<=0 for that channel.
  - Write has priority over start and mode change on the same channel in the same cycle.
- Rejected write (wr_en=1 and either wr_div==0 or wr_ch>=NCH): no state changes; err<=1 for one cycle. Otherwise err<=0.
- Arithmetic: cnt compared against div-1 in W bits. div is never 0, so there is no underflow. cnt never exceeds div-1 because every div change also clears cnt.

## Timing
- Reset (reset_n low, asynchronous):
  - cnt=0, div=DEF_DIV, busy=0, mode_q=0, tick=0, err=0.
  - Outputs are held low for the whole reset period.
- Periodic channel: if ch_en is first sampled high at edge E1, tick is high during the cycle after edge E1+DIV-1. The tick is then repeated every DIV cycles, and each tick is exactly one cycle wide.
- DIV=1: tick stays high continuously while the channel is active.
- One-shot channel: with start sampled at edge S:
  - busy rises after S.
  - At edge S+DIV, tick rises for one cycle and busy falls at the same edge.
- Write latency: the new divisor takes effect at the write edge. The first tick after a write follows the same rule as E1, with E1 = write edge + 1.
- err: rises one cycle after the rejected write, one cycle wide.
- reset_n deasserting mid-count: no partial state survives; all channels restart from cnt=0.

## Test plan
- Periodic counting:
  - Stimulus: reset, DEF_DIV=5 (sim override), ch_en=1 on channel 0.
  - Expect: tick[0] one cycle wide with period exactly 5; other channels stay silent while their ch_en=0.
- Divisor writes:
  - Stimulus: write div=1 to channel 1, then div=3 while channel 1 is mid-count.
  - Expect: tick[1] constant high under div=1; after the div=3 write, first tick 3 cycles after the write edge, with no stray tick.
- One-shot:
  - Stimulus: channel 2 one-shot, div=4, start pulse.
  - Expect: busy for 4 cycles, a single tick, busy=0; no further ticks.
  - Stimulus: retrigger at count 2.
  - Expect: tick 4 cycles after the retrigger edge.
- Rejected writes:
  - Stimulus: write wr_div=0, and a write with wr_ch>=NCH (NCH=3 build).
  - Expect: err one-cycle pulse each time; divisors and counters unchanged.
- Abort paths:
  - Stimulus: drop ch_en mid one-shot; toggle ch_oneshot mid periodic count; write and start on the same channel in the same cycle.
  - Expect: busy=0 and cnt cleared in each case; the write wins over start.
- Asynchronous reset:
  - Stimulus: assert reset_n low between clock edges while all channels are active.
  - Expect: tick/busy/err low immediately; after release, all divisors equal DEF_DIV.
